// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, DRAIN)
//   rr_pick     : round-robin winner index from a request vector and the
//                 index of the last grant; search starts at last+1 mod num.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int MAX_PORTS = 4;
  localparam int PICK_W    = 2;

  // Walk the candidates from farthest to nearest so that the nearest
  // requester after 'last' overwrites any farther one. With no request the
  // result is 'last' (callers gate on any_req).
  function automatic logic [PICK_W-1:0] rr_pick(
      input logic [MAX_PORTS-1:0] req,
      input logic [PICK_W-1:0]    last,
      input int                   num);
    logic [PICK_W-1:0] pick;
    int                idx;
    pick = last;
    for (int k = MAX_PORTS; k >= 1; k--) begin
      if (k <= num) begin
        idx = (int'(last) + k) % num;
        if (req[idx]) pick = PICK_W'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared resource.
//   req          : per-requester request level
//   last_grant   : index of the previously served requester
//   grant_onehot : one-hot winner (all zero when nothing requests)
//   grant_idx    : binary winner index (valid when any_req)
//   any_req      : at least one request is present
module rr_arbiter import dram_arb_pkg::*; #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any_req
);

  logic [MAX_PORTS-1:0] req_ext;
  logic [PICK_W-1:0]    last_ext;
  logic [PICK_W-1:0]    pick;

  assign any_req = |req;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_PORTS-1:0]   = req;
    last_ext                 = PICK_W'(last_grant);
    pick                     = rr_pick(req_ext, last_ext, NUM_PORTS);
    grant_idx                = IDX_W'(pick);
    grant_onehot             = '0;
    if (any_req) grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin front end that lets NUM_PORTS masters share the single
// requester interface of the SDRAM controller.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   port_req/addr/wdata/we/be        : per-master command, held until ack
//   port_ack                         : one-cycle completion pulse per master
//   port_rdata                       : read data of the last completion
//   mem_req/addr/wdata/we/be         : latched command to the controller
//   mem_rdata, mem_ack               : controller read data and level ack
//   grant_id                         : current or last granted master
//   busy                             : request outstanding or draining
//   timeout_err                      : sticky, controller took too long
module dram_port_arbiter import dram_arb_pkg::*; #(
  parameter  int NUM_PORTS      = 2,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int DATA_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int GID_W          = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 port_req,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata,
  input  logic [NUM_PORTS-1:0]                 port_we,
  input  logic [NUM_PORTS-1:0][3:0]            port_be,
  output logic [NUM_PORTS-1:0]                 port_ack,
  output logic [DATA_WIDTH-1:0]                port_rdata,
  output logic                                 mem_req,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic                                 mem_we,
  output logic [3:0]                           mem_be,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  input  logic                                 mem_ack,
  output logic [GID_W-1:0]                     grant_id,
  output logic                                 busy,
  output logic                                 timeout_err
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMAX  = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t             state, state_next;
  logic [GID_W-1:0]       last_grant;
  logic                   ack_q;
  logic [CNT_W-1:0]       tcnt;
  logic [NUM_PORTS-1:0]   win_onehot;
  logic [GID_W-1:0]       win_idx;
  logic                   any_req;
  logic                   grant_fire;
  logic                   complete;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_we;
  logic [3:0]             sel_be;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req          (port_req),
    .last_grant   (last_grant),
    .grant_onehot (win_onehot),
    .grant_idx    (win_idx),
    .any_req      (any_req)
  );

  // AND-OR command mux driven by the one-hot winner.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (win_onehot[i]) begin
        sel_addr  = sel_addr  | port_addr[i];
        sel_wdata = sel_wdata | port_wdata[i];
        sel_we    = sel_we    | port_we[i];
        sel_be    = sel_be    | port_be[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A stale acknowledge in IDLE blocks new grants; completion is the rising
  // edge of mem_ack because the controller holds ack high for a while.
  always_comb begin
    state_next = state;
    grant_fire = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_ack && any_req) begin
          grant_fire = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack && !ack_q) begin
          complete   = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Command latch, completion and grant bookkeeping. The mem_* command is
  // only written on a grant, so it stays frozen for the whole BUSY period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      port_ack   <= '0;
      port_rdata <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      grant_id   <= '0;
      last_grant <= GID_W'(NUM_PORTS - 1);
    end else begin
      ack_q    <= mem_ack;
      port_ack <= '0;
      if (grant_fire) begin
        mem_req   <= 1'b1;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_we    <= sel_we;
        mem_be    <= sel_be;
        grant_id  <= win_idx;
      end
      if (complete) begin
        mem_req            <= 1'b0;
        port_ack[grant_id] <= 1'b1;
        port_rdata         <= mem_rdata;
        last_grant         <= grant_id;
      end
    end
  end

  // Watchdog: counts BUSY cycles since the grant and flags a stuck
  // controller without abandoning the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else if (grant_fire) begin
      tcnt <= '0;
    end else if (state == BUSY && tcnt != TMAX) begin
      tcnt <= tcnt + 1'b1;
      if (tcnt == TMAX - 1'b1) timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Round-robin arbiter that shares the single-requester core interface of the SDRAM controller between `NUM_PORTS` bus masters, for example instruction fetch and load/store. It sits between the masters and the controller. It latches one winning request and holds it stable until the controller's acknowledge rises. It then returns read data and a one-cycle acknowledge to the winner. The controller's acknowledge stays high for several cycles after completion, so the arbiter waits for it to fall before issuing the next request.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of requesters (2–4 supported).
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width.
- `TIMEOUT_CYCLES`, default 1024: BUSY cycles before `timeout_err` sets.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `port_req`  in  [NUM_PORTS]: per-port request level.
- `port_addr`  in  [NUM_PORTS][ADDR_WIDTH]: per-port address.
- `port_wdata`  in  [NUM_PORTS][DATA_WIDTH]: per-port write data.
- `port_we`  in  [NUM_PORTS]: per-port write enable.
- `port_be`  in  [NUM_PORTS][4]: per-port byte enables.
- `port_ack`  out  [NUM_PORTS]: one-cycle completion pulse.
- `port_rdata`  out  DATA_WIDTH: shared read data, valid while the matching `port_ack` is high.
- `mem_req`  out  1: request to the controller.
- `mem_addr`, `mem_wdata`, `mem_we`, `mem_be`  out: latched command, widths as the per-port inputs.
- `mem_rdata`  in  DATA_WIDTH: controller read data.
- `mem_ack`  in  1: controller acknowledge, level.
- `grant_id`  out  $clog2(NUM_PORTS): index of the current or last grant.
- `busy`  out  1: high in BUSY and DRAIN.
- `timeout_err`  out  1: sticky; cleared only by reset.

## Operation
- **Upstream rule:** a master asserts `port_req[i]` and holds `port_req[i]`, address, data, `we` and `be` stable until `port_ack[i]` pulses. It may deassert in the cycle after the ack, or keep `req` high to issue back-to-back requests.
- **States:** IDLE, BUSY, DRAIN.
- **IDLE:**
  - When `mem_ack`==0 and any `port_req` is high, select the winner by round-robin, starting from `last_grant+1` modulo `NUM_PORTS`.
  - Register the winner's address, wdata, we and be into the `mem_*` outputs.
  - Set `mem_req`=1, set `grant_id`=winner, then go to BUSY.
  - If `mem_ack`==1 in IDLE (stale acknowledge), stay in IDLE and issue nothing.
- **BUSY:**
  - All `mem_*` outputs are held constant. The controller samples `mem_we` after its own address latch, so stability is mandatory.
  - A rising edge of `mem_ack` (`mem_ack`=1 and registered `ack_q`=0) completes the request. On completion:
    - `port_ack[grant_id]` pulses for 1 cycle.
    - `port_rdata` takes `mem_rdata` (for writes too; its value is don't-care).
    - `mem_req` goes to 0, `last_grant` takes `grant_id`, then go to DRAIN.
- **DRAIN:** when `mem_ack`==0, go to IDLE.
- **Timeout:**
  - A counter clears on entry to BUSY and increments each BUSY cycle, saturating.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` sets to 1.
  - The request is NOT abandoned; the arbiter keeps waiting in BUSY.
- **Arbitration boundaries:**
  - A request that arrives during BUSY or DRAIN waits.
  - A request withdrawn before grant is simply not served.
  - When only one port requests, it is granted every round.
  - With all ports continuously requesting, grants rotate 0,1,…,N-1,0.

## Timing
- **Reset values:** all outputs 0; state IDLE; `last_grant`=NUM_PORTS-1, so port 0 wins first.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs 0. No port ack is issued for the in-flight request.
- **Grant latency:** request high at edge N in IDLE → `mem_req` and `mem_*` valid after edge N.
- **Completion latency:** `mem_ack` rising sampled at edge M → `port_ack` and `port_rdata` valid after edge M for exactly 1 cycle; `mem_req` low after edge M.
- **Minimum turnaround:** from `mem_ack` falling sampled at edge K, the arbiter is in IDLE after K. The next `mem_req` goes out after edge K+1.
- `port_rdata` holds its value until the next completion.

## Structure
- **Package `dram_arb_pkg`:**
  - `arb_state_t` enum (IDLE, BUSY, DRAIN).
  - Function returning the round-robin winner from a request vector and last grant.
- **Sub-module `rr_arbiter`:** combinational request vector plus `last_grant` → one-hot winner, binary index and `any_req`. It is reused by later shared-resource arbiters.
- **Top level:** FSM, command latch, `ack_q` edge detector and timeout counter.

## Test plan
- **Single read:** port 0 reads 0x0000_0100; model acks after 8 cycles with rdata 0xDEAD_BEEF, held high for 3 cycles → `port_ack[0]` is a 1-cycle pulse, `port_rdata`=0xDEAD_BEEF, `mem_addr` stable throughout BUSY, exactly one grant.
- **Contention:** ports 0 and 1 both request continuously for 4 transactions → `grant_id` sequence 0,1,0,1; each port receives 2 acks.
- **Stale ack:** `mem_ack` forced high at the moment port 1 requests → no `mem_req` until `mem_ack` falls; then port 1 is granted.
- **Write stability:** port 1 writes 0x1234_5678, be=4'b0011, while port 0 toggles its inputs → `mem_wdata`, `mem_be` and `mem_we` stay unchanged until the ack.
- **Timeout:** model never acks, `TIMEOUT_CYCLES`=16 → `timeout_err`=1 after 16 BUSY cycles; a later ack still completes normally and `timeout_err` stays 1.
- **Reset mid-BUSY:** assert `rst_n`=0 mid-request → all outputs 0 immediately and no `port_ack`; after release, port 0 wins first.
